stall_one: RTL and testbench
============================

// Module: stall_one
// PURPOSE
// - Load-use hazard unit plus bubble-inserting ID/EX instruction register for the 5-stage MIPS pipeline.
// - Compares the instruction in decode (in1) with the instruction now in execute (in2).
// - On a load-use hazard it asserts stall for exactly one cycle and clocks a NOP into the ID/EX instruction
//   slot; otherwise it clocks in1 through unchanged.
// - Sits between the IF/ID register and the ID/EX register.
// PARAMETERS
// - WIDTH   32          instruction word width; only 32 is supported
// - NOP     32'h0000_0000  bubble word loaded on a stall (sll $0,$0,0)
// PORTS
// - clk    in   1   rising-edge clock
// - rst    in   1   asynchronous, active-high reset
// - in1    in   32  instruction in decode (IF/ID output)
// - in2    in   32  instruction in execute (ID/EX output, normally fed back from out)
// - out    out  32  registered instruction for ID/EX
// - stall  out  1   combinational; freezes PC and IF/ID when high
// BEHAVIOUR
// - Fields: op=[31:26], rs=[25:21], rt=[20:16].
// - in2 is a load when in2.op == 6'b100011 (lw) and in2.rt != 0.
// - in1 reads rs for every opcode.
// - in1 reads rt only for op 000000 (R-type), 000100 (beq), 000101 (bne) and 101011 (sw).
// - hazard = load(in2) && (in2.rt == in1.rs || (in1 reads rt && in2.rt == in1.rt)).
// - stall = hazard && !bubble_q; it is purely combinational from in1, in2 and bubble_q.
// - bubble_q: internal flag, set on any edge where stall=1, cleared on any edge where stall=0.
//   - Result: at most one stall cycle per hazard, even if in2 is held at the load word.
// - Posedge clk:
//   - out <= stall ? NOP : in1
//   - bubble_q <= stall
// - Latency: one cycle from in1 to out.
// - Reset (rst=1, asynchronous):
//   - out = 32'h0 and bubble_q = 0 immediately; stall follows combinationally (in2 reads 0, so stall=0).
//   - Reset asserted mid-stall aborts the stall; the next post-reset edge registers in1 normally.
// - rt==0 loads ($zero) never stall.
// - A NOP or any non-lw in2 never stalls.
// - X on in1 or in2 while not in reset: no requirement.
// TESTING
// - Reset: rst=1 with in1=0x010A4820 -> out=0, stall=0; release rst, one edge -> out=0x010A4820.
// - Load-use on rs: in2=0x8E080000 (lw $t0,0($s0)), in1=0x010A4820 (add $t1,$t0,$t2).
//   - stall=1 now; next edge out=0x00000000.
//   - With in2 held, stall=0 on the following cycle and the next edge gives out=0x010A4820.
// - Load-use on rt via sw: in2=0x8E080000, in1=0xAE280004 (sw $t0,4($s1)) -> stall=1, next out=0.
// - No hazard: in2=0x8E080000 with in1=0x016A4820 (add $t1,$t3,$t2), or with in1=0x21680001
//   (addi $t0,$t3,1; rt is a destination, not a source) -> stall=0, next out=in1.
// - $zero load: in2=0x8E000000, in1=0x00004820 -> stall=0, out=in1.
// - Reset during stall: assert rst while stall=1 -> out=0 and bubble_q=0 at once; after release the
//   pipeline resumes normally.

Source files
------------

// File: rtl/stall_one.sv
// Load-use hazard detector plus the ID/EX instruction register it feeds.
// A detected hazard stalls for a single cycle and clocks a NOP bubble into ID/EX.
module stall_one #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             stall
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  logic [WIDTH-1:0] out_q, out_d;
  logic             bubble_q, bubble_d;

  logic [OP_W-1:0]  in1_op, in2_op;
  logic [REG_W-1:0] in1_rs, in1_rt, in2_rt;
  logic             in2_is_load, in1_reads_rt, hazard, stall_c;

  // Only op and rt of the execute-stage word matter for hazard detection.
  logic unused_in2;
  assign unused_in2 = ^{in2[25:21], in2[15:0]};

  assign in1_op = in1[31:26];
  assign in1_rs = in1[25:21];
  assign in1_rt = in1[20:16];
  assign in2_op = in2[31:26];
  assign in2_rt = in2[20:16];

  // Hazard detection and next-state for the bubble register.
  always_comb begin
    in1_reads_rt = 1'b0;
    in2_is_load  = 1'b0;
    hazard       = 1'b0;
    stall_c      = 1'b0;
    out_d        = in1;
    bubble_d     = 1'b0;

    case (in1_op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: in1_reads_rt = 1'b1;
      default:                         in1_reads_rt = 1'b0;
    endcase

    in2_is_load = (in2_op == OP_LW) && (in2_rt != REG_W'(0));
    hazard      = in2_is_load &&
                  ((in2_rt == in1_rs) || (in1_reads_rt && (in2_rt == in1_rt)));
    // bubble_q masks the second cycle so a held load word cannot stall twice.
    stall_c     = hazard && !bubble_q;
    out_d       = stall_c ? NOP : in1;
    bubble_d    = stall_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      bubble_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      bubble_q <= bubble_d;
    end
  end

  assign out   = out_q;
  assign stall = stall_c;

endmodule

// File: tb/tb_stall_one.sv
// Scoreboard bench for stall_one: a driver pushes expected {stall, out} per cycle,
// a monitor pops and compares; expectations come from a spec-level hazard model.
module tb_stall_one;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [31:0] out;
  logic        stall;

  stall_one dut (
    .clk  (clk),
    .rst  (rst),
    .in1  (in1),
    .in2  (in2),
    .out  (out),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        s;
    logic [31:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   m_bubble = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
  endtask

  // Reference: load-use rule written straight from field arithmetic.
  function automatic bit hazard_ref(input logic [31:0] i1, input logic [31:0] i2);
    int op1, rs1, rt1, op2, rt2;
    bit reads_rt;
    op1 = int'(i1 >> 26);
    rs1 = int'((i1 >> 21) & 32'd31);
    rt1 = int'((i1 >> 16) & 32'd31);
    op2 = int'(i2 >> 26);
    rt2 = int'((i2 >> 16) & 32'd31);
    reads_rt = (op1 == 0) || (op1 == 4) || (op1 == 5) || (op1 == 43);
    if (op2 != 35 || rt2 == 0) return 1'b0;
    return (rt2 == rs1) || (reads_rt && rt2 == rt1);
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    in1 = a;
    in2 = b;
    e.s = hazard_ref(a, b) && !m_bubble;
    e.o = e.s ? 32'h0 : a;
    m_bubble = e.s;
    exp_q.push_back(e);
  endtask

  // Reset asserted asynchronously mid-cycle and held across one edge.
  task automatic do_reset(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    in1 = a;
    in2 = b;
    #1 rst = 1'b1;
    m_bubble = 1'b0;
    e.s = hazard_ref(a, b);
    e.o = 32'h0;
    #1;
    chk("async_rst_out", out, 32'h0);
    chk("async_rst_stall", {31'h0, stall}, {31'h0, e.s});
    exp_q.push_back(e);
  endtask

  // Monitor: stall sampled late in the low phase, out sampled just after the edge.
  initial begin
    logic s_samp;
    exp_t e;
    forever begin
      @(negedge clk);
      #3 s_samp = stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall", {31'h0, s_samp}, {31'h0, e.s});
        chk("out", out, e.o);
      end
    end
  end

  function automatic logic [31:0] rand_in1();
    logic [5:0] ops[8] = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd8, 6'd35, 6'd2, 6'd15};
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic [15:0] imm;
    op  = ops[$urandom_range(0, 7)];
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_in2();
    logic [4:0] rs, rt;
    logic [15:0] imm;
    if ($urandom_range(0, 1) == 0) return 32'($urandom);
    rs  = 5'($urandom);
    rt  = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    return {6'b100011, rs, rt, imm};
  endfunction

  initial begin
    logic [31:0] r2;
    int waited;
    do_reset(32'h010A4820, 32'h0);
    step(32'h010A4820, 32'h0);
    // Load-use on rs, then held load word must not stall again.
    step(32'h010A4820, 32'h8E080000);
    step(32'h010A4820, 32'h8E080000);
    // Load-use on rt through sw.
    step(32'hAE280004, 32'h8E080000);
    step(32'h016A4820, 32'h8E080000);
    step(32'h016A4820, 32'h8E080000);
    step(32'h21680001, 32'h8E080000);
    // $zero load.
    step(32'h00004820, 32'h8E000000);
    // Reset while a stall is being presented.
    step(32'h016A4820, 32'h0);
    do_reset(32'h010A4820, 32'h8E080000);
    step(32'h010A4820, 32'h0);
    // Reset after the bubble cycle with the load word held.
    step(32'h010A4820, 32'h8E080000);
    do_reset(32'h010A4820, 32'h8E080000);
    step(32'h010A4820, 32'h0);

    r2 = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) r2 = rand_in2();
      if ($urandom_range(0, 39) == 0) do_reset(rand_in1(), r2);
      else step(rand_in1(), r2);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
